// File: rtl/top_level.sv
// Two-region memory-side cache: 4-way write-back cache for region 2, 4-way write-through for region 3.
// Optional CACHE_STATS_EN adds saturating hit/miss counters on hit_count/miss_count.
module top_level #(
   parameter int WAYS      = 4,
   parameter int SETS      = 4,
   parameter int INDEX_LSB = 8,
   parameter int MEM_AW    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        is_write,
   input  logic [31:0] write_data,
   output logic        hit,
   output logic [31:0] read_data
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   localparam int SET_W = $clog2(SETS);
   localparam int WAY_W = 2;
   localparam int TAG_W = 24;

   logic              valid_q [2][SETS][WAYS];
   logic              dirty_q [2][SETS][WAYS];
   logic [WAY_W-1:0]  age_q   [2][SETS][WAYS];
   logic [TAG_W-1:0]  tag_q   [2][SETS][WAYS];
   logic [31:0]       data_q  [2][SETS][WAYS];
   logic [31:0]       mem_q   [4*(2**MEM_AW)];

   logic              cached;
   logic              c_sel;
   logic [SET_W-1:0]  set_idx;
   logic [TAG_W-1:0]  tag;
   logic [MEM_AW+1:0] mem_idx;
   logic              lookup_hit;
   logic              any_invalid;
   logic [WAY_W-1:0]  hit_way;
   logic [WAY_W-1:0]  inv_way;
   logic [WAY_W-1:0]  old_way;
   logic [WAY_W-1:0]  vict_way;
   logic [WAY_W-1:0]  acc_way;
   logic              access;
   logic              do_wb;
   logic [MEM_AW+1:0] wb_idx;

   assign cached  = (address[31:28] == 4'd2) || (address[31:28] == 4'd3);
   assign c_sel   = address[28];
   assign set_idx = address[INDEX_LSB +: SET_W];
   assign tag     = address[27:4];
   assign mem_idx = {address[29:28], address[MEM_AW+3:4]};

   // Descending scan so the lowest-index invalid way wins.
   always_comb begin
      lookup_hit  = 1'b0;
      any_invalid = 1'b0;
      hit_way     = '0;
      inv_way     = '0;
      old_way     = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (valid_q[c_sel][set_idx][w] && (tag_q[c_sel][set_idx][w] == tag)) begin
            lookup_hit = 1'b1;
            hit_way    = WAY_W'(w);
         end
         if (!valid_q[c_sel][set_idx][w]) begin
            any_invalid = 1'b1;
            inv_way     = WAY_W'(w);
         end
         if (age_q[c_sel][set_idx][w] == 2'd3)
            old_way = WAY_W'(w);
      end
   end

   assign vict_way = any_invalid ? inv_way : old_way;
   assign acc_way  = lookup_hit ? hit_way : vict_way;
   assign access   = cached && (is_write || lookup_hit);
   assign do_wb    = cached && is_write && !c_sel && !lookup_hit
                     && valid_q[c_sel][set_idx][vict_way] && dirty_q[c_sel][set_idx][vict_way];
   assign wb_idx   = {2'b10, tag_q[c_sel][set_idx][vict_way][MEM_AW-1:0]};

   assign hit       = reset && cached && lookup_hit;
   assign read_data = !reset ? 32'd0 :
                      (hit ? data_q[c_sel][set_idx][hit_way] : mem_q[mem_idx]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < 2; c++)
            for (int s = 0; s < SETS; s++)
               for (int w = 0; w < WAYS; w++) begin
                  valid_q[c][s][w] <= 1'b0;
                  dirty_q[c][s][w] <= 1'b0;
                  age_q[c][s][w]   <= WAY_W'(w);
               end
      end else if (access) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == acc_way)
               age_q[c_sel][set_idx][w] <= '0;
            else if (age_q[c_sel][set_idx][w] < age_q[c_sel][set_idx][acc_way])
               age_q[c_sel][set_idx][w] <= age_q[c_sel][set_idx][w] + 2'd1;
         end
         if (is_write) begin
            valid_q[c_sel][set_idx][acc_way] <= 1'b1;
            dirty_q[c_sel][set_idx][acc_way] <= !c_sel;
         end
      end
   end

   // Line payload and backing store carry no reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if (reset && is_write) begin
         if (cached) begin
            tag_q[c_sel][set_idx][acc_way]  <= tag;
            data_q[c_sel][set_idx][acc_way] <= write_data;
         end
         if (!cached || c_sel)
            mem_q[mem_idx] <= write_data;
         else if (do_wb)
            mem_q[wb_idx] <= data_q[c_sel][set_idx][vict_way];
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (cached) begin
         if (lookup_hit && (hit_count != 16'hFFFF))
            hit_count <= hit_count + 16'd1;
         if (!lookup_hit && (miss_count != 16'hFFFF))
            miss_count <= miss_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_top_level.sv
// Directed self-checking bench for top_level: eviction, writeback, write-through, LRU, uncached, reset.
module tb_top_level;

   logic        clk;
   logic        reset;
   logic [31:0] address;
   logic        is_write;
   logic [31:0] write_data;
   logic        hit;
   logic [31:0] read_data;
`ifdef CACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   int errors = 0;
   int checks = 0;

   top_level dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .is_write   (is_write),
      .write_data (write_data),
      .hit        (hit),
`ifdef CACHE_STATS_EN
      .hit_count  (hit_count),
      .miss_count (miss_count),
`endif
      .read_data  (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      is_write = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      write_data = d;
      is_write   = 1'b1;
      @(negedge clk);
      is_write   = 1'b0;
   endtask

   task automatic rd_hit(input string tag, input logic [31:0] a, input logic eh);
      @(negedge clk);
      address  = a;
      is_write = 1'b0;
      #1;
      check_val({tag, "_hit"}, {31'd0, hit}, {31'd0, eh});
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic eh, input logic [31:0] ed);
      rd_hit(tag, a, eh);
      check_val({tag, "_data"}, read_data, ed);
   endtask

   initial begin
      reset      = 1'b0;
      address    = '0;
      is_write   = 1'b0;
      write_data = '0;
      #12;

      // reset state
      do_reset();
      rd_hit("reset_miss", 32'h2000_0000, 1'b0);

      // region 2 write-back eviction
      do_write(32'h2000_0000, 32'h1111_0000);
      do_write(32'h2000_0010, 32'h2222_0000);
      do_write(32'h2000_0020, 32'h3333_0000);
      do_write(32'h2000_0030, 32'h4444_0000);
      do_write(32'h2000_0040, 32'h5555_0000);
      rd("r2_00", 32'h2000_0000, 1'b0, 32'h1111_0000);
      rd("r2_10", 32'h2000_0010, 1'b1, 32'h2222_0000);
      rd("r2_20", 32'h2000_0020, 1'b1, 32'h3333_0000);
      rd("r2_30", 32'h2000_0030, 1'b1, 32'h4444_0000);
      rd("r2_40", 32'h2000_0040, 1'b1, 32'h5555_0000);

      // region 3 write-through eviction
      do_write(32'h3000_0000, 32'hAAAA_0000);
      do_write(32'h3000_0010, 32'hBBBB_0000);
      do_write(32'h3000_0020, 32'hCCCC_0000);
      do_write(32'h3000_0030, 32'hDDDD_0000);
      do_write(32'h3000_0040, 32'hEEEE_0000);
      rd("r3_00", 32'h3000_0000, 1'b0, 32'hAAAA_0000);
      rd("r3_10", 32'h3000_0010, 1'b1, 32'hBBBB_0000);
      rd("r3_20", 32'h3000_0020, 1'b1, 32'hCCCC_0000);
      rd("r3_30", 32'h3000_0030, 1'b1, 32'hDDDD_0000);
      rd("r3_40", 32'h3000_0040, 1'b1, 32'hEEEE_0000);

      // dirty line dropped by reset; memory keeps the older written-back value
      do_reset();
      do_write(32'h2000_0000, 32'h9999_0000);
      rd("dirty_line", 32'h2000_0000, 1'b1, 32'h9999_0000);
      do_reset();
      rd("dirty_drop", 32'h2000_0000, 1'b0, 32'h1111_0000);

      // LRU: touching way 0 makes way 1 the victim
      do_reset();
      do_write(32'h2000_0000, 32'h0000_0001);
      do_write(32'h2000_0010, 32'h0000_0002);
      do_write(32'h2000_0020, 32'h0000_0003);
      do_write(32'h2000_0030, 32'h0000_0004);
      rd("lru_touch", 32'h2000_0000, 1'b1, 32'h0000_0001);
      do_write(32'h2000_0040, 32'h0000_0005);
      rd("lru_keep", 32'h2000_0000, 1'b1, 32'h0000_0001);
      rd("lru_evict", 32'h2000_0010, 1'b0, 32'h0000_0002);
      rd("lru_new", 32'h2000_0040, 1'b1, 32'h0000_0005);

      // write-through survives reset
      do_write(32'h3000_0100, 32'h1234_5678);
      rd("wt_hit", 32'h3000_0100, 1'b1, 32'h1234_5678);
      do_reset();
      rd("wt_mem", 32'h3000_0100, 1'b0, 32'h1234_5678);

      // uncached region
      do_write(32'h1000_0004, 32'hDEAD_BEEF);
      rd("uncached", 32'h1000_0004, 1'b0, 32'hDEAD_BEEF);

      // reset mid-operation
      do_reset();
      do_write(32'h2000_0000, 32'h0A0A_0000);
      do_write(32'h2000_0010, 32'h0B0B_0000);
      do_write(32'h2000_0020, 32'h0C0C_0000);
      do_write(32'h2000_0030, 32'h0D0D_0000);
      rd("pre_rst", 32'h2000_0010, 1'b1, 32'h0B0B_0000);
      @(negedge clk);
      reset   = 1'b0;
      address = 32'h2000_0010;
      #1;
      check_val("in_rst_hit", {31'd0, hit}, 32'd0);
      check_val("in_rst_data", read_data, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      rd_hit("post_rst", 32'h2000_0010, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
